// File: rtl/timer_counter.sv
// timer_counter: memory-mapped down-counter with one-shot / auto-reload modes.
// The window holds CTRL (+0), PRESET (+4), COUNT (+8, read-only) and a zero word (+C).
// irq is the expiry flag gated by the CTRL interrupt mask.
module timer_counter #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CNT,
        ST_INT
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;      // {IM, MODE[1:0], EN}
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        flag_q, flag_d;
    logic        flag_fsm;
    logic        en_clr;

    logic        hit;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        en;
    logic [1:0]  mode;
    logic        unused_addr;

    assign hit         = (addr[31:4] == BASE_ADDR[31:4]);
    assign wr_ctrl     = hit && (byteen != 4'b0000) && (addr[3:2] == 2'd0);
    assign wr_preset   = hit && (byteen != 4'b0000) && (addr[3:2] == 2'd1);
    assign en          = ctrl_q[0];
    assign mode        = ctrl_q[2:1];
    assign irq         = flag_q & ctrl_q[3];
    assign unused_addr = ^addr[1:0];

    // Counter sequencing: next state, COUNT and the FSM's view of the flag
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        flag_fsm = flag_q;
        en_clr   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                count_d  = preset_q;
                flag_fsm = 1'b0;
                state_d  = ST_CNT;
            end
            ST_CNT: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d  = '0;
                    flag_fsm = 1'b1;
                    state_d  = ST_INT;
                end
            end
            ST_INT: begin
                if (mode == 2'b01) begin
                    flag_fsm = 1'b0;
                    state_d  = en ? ST_LOAD : ST_IDLE;
                end else begin
                    en_clr  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus writes merged over FSM updates; a CTRL lane-0 write beats the EN clear
    always_comb begin
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        flag_d   = flag_fsm;
        if (en_clr) ctrl_d[0] = 1'b0;
        if (wr_ctrl && byteen[0]) ctrl_d = wdata[3:0];
        for (int unsigned i = 0; i < 4; i++) begin
            if (wr_preset && byteen[i]) preset_d[8*i +: 8] = wdata[8*i +: 8];
        end
        // A held flag is only ever set while no write is pending on it, so
        // clearing on flag_q never cancels a fresh expiry.
        if ((wr_ctrl || wr_preset) && flag_q) flag_d = 1'b0;
    end

    // Combinational read mux, zero outside the window
    always_comb begin
        rdata = '0;
        if (hit) begin
            case (addr[3:2])
                2'd0:    rdata = {28'd0, ctrl_q};
                2'd1:    rdata = preset_q;
                2'd2:    rdata = count_q;
                default: rdata = '0;
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: directed vector table, hand-written timing
// sequences, and randomized bus traffic against a behavioural model.
module tb_timer_counter;

    localparam logic [31:0] BASE   = 32'h0000_7F00;
    localparam logic [31:0] A_CTRL = BASE + 32'h0;
    localparam logic [31:0] A_PRE  = BASE + 32'h4;
    localparam logic [31:0] A_CNT  = BASE + 32'h8;
    localparam logic [31:0] A_RSV  = BASE + 32'hC;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    timer_counter #(.BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .byteen(byteen),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_RUN = 2, PH_DONE = 3;
    int          m_phase  = PH_IDLE;
    bit          m_en     = 0;
    bit [1:0]    m_mode   = 0;
    bit          m_im     = 0;
    bit [31:0]   m_preset = 0;
    bit [31:0]   m_count  = 0;
    bit          m_flag   = 0;

    task automatic model_step();
        bit hit, wctl, wpre, old_flag, en_new;
        int nxt;
        hit  = (addr[31:4] == BASE[31:4]);
        wctl = hit && (byteen != 0) && (addr[3:2] == 2'd0);
        wpre = hit && (byteen != 0) && (addr[3:2] == 2'd1);
        if (reset) begin
            m_phase = PH_IDLE; m_en = 0; m_mode = 0; m_im = 0;
            m_preset = 0; m_count = 0; m_flag = 0;
            return;
        end
        old_flag = m_flag;
        en_new   = m_en;
        nxt      = m_phase;
        case (m_phase)
            PH_IDLE: if (m_en) nxt = PH_LOAD;
            PH_LOAD: begin m_count = m_preset; m_flag = 0; nxt = PH_RUN; end
            PH_RUN: begin
                if (!m_en) nxt = PH_IDLE;
                else if (m_count > 1) m_count = m_count - 1;
                else begin m_count = 0; m_flag = 1; nxt = PH_DONE; end
            end
            default: begin
                if (m_mode == 2'b01) begin
                    m_flag = 0;
                    nxt = m_en ? PH_LOAD : PH_IDLE;
                end else begin
                    en_new = 0;
                    nxt = PH_IDLE;
                end
            end
        endcase
        if ((wctl || wpre) && old_flag) m_flag = 0;
        if (wctl && byteen[0]) begin
            m_en = wdata[0]; m_mode = wdata[2:1]; m_im = wdata[3];
        end else begin
            m_en = en_new;
        end
        for (int i = 0; i < 4; i++)
            if (wpre && byteen[i]) m_preset[8*i +: 8] = wdata[8*i +: 8];
        m_phase = nxt;
    endtask

    function automatic logic [31:0] mread(logic [31:0] a);
        if (a[31:4] != BASE[31:4]) return 32'd0;
        case (a[3:2])
            2'd0:    return {28'd0, m_im, m_mode, m_en};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) model_step();

    // ---------------- helpers ----------------
    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(bit r, logic [31:0] a, logic [3:0] be, logic [31:0] wd);
        reset = r; addr = a; byteen = be; wdata = wd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] wd);
        drive(0, a, 4'hF, wd);
        tick();
    endtask

    task automatic rd(logic [31:0] a);
        drive(0, a, 4'h0, 32'd0);
    endtask

    task automatic do_reset();
        drive(1, A_CTRL, 4'h0, 32'd0);
        tick();
        tick();
        drive(0, A_CTRL, 4'h0, 32'd0);
    endtask

    typedef struct {
        bit          rst;
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        bit          exp_irq;
        bit          chk;
    } vec_t;

    vec_t tbl[$];

    initial begin
        reset = 1'b1; addr = '0; byteen = '0; wdata = '0;
        @(negedge clk);

        // rdata is checked before each vector's own edge takes effect
        tbl.push_back('{1, A_CTRL, 4'h0, 32'h0, 32'h0, 0, 0});
        tbl.push_back('{1, A_CTRL, 4'h0, 32'h0, 32'h0, 0, 1});
        tbl.push_back('{0, A_CTRL, 4'h0, 32'h0, 32'h0, 0, 1});
        tbl.push_back('{0, A_PRE,  4'h0, 32'h0, 32'h0, 0, 1});
        tbl.push_back('{0, A_CNT,  4'h0, 32'h0, 32'h0, 0, 1});
        tbl.push_back('{0, A_RSV,  4'h0, 32'h0, 32'h0, 0, 1});
        tbl.push_back('{0, A_PRE,  4'hF, 32'h11223344, 32'h0, 0, 1});
        tbl.push_back('{0, A_PRE,  4'h0, 32'h0, 32'h11223344, 0, 1});
        tbl.push_back('{0, A_PRE,  4'h2, 32'h0000AA00, 32'h11223344, 0, 1});
        tbl.push_back('{0, A_PRE,  4'h0, 32'h0, 32'h1122AA44, 0, 1});
        tbl.push_back('{0, BASE + 32'h10, 4'hF, 32'hFFFFFFFF, 32'h0, 0, 1});
        tbl.push_back('{0, A_CTRL, 4'h0, 32'h0, 32'h0, 0, 1});
        tbl.push_back('{0, A_PRE,  4'h0, 32'h0, 32'h1122AA44, 0, 1});
        tbl.push_back('{0, A_CNT,  4'hF, 32'h12345678, 32'h0, 0, 1});
        tbl.push_back('{0, A_CNT,  4'h0, 32'h0, 32'h0, 0, 1});
        tbl.push_back('{0, A_RSV,  4'hF, 32'hFFFFFFFF, 32'h0, 0, 1});
        tbl.push_back('{0, A_RSV,  4'h0, 32'h0, 32'h0, 0, 1});
        tbl.push_back('{0, A_CTRL, 4'h1, 32'hFFFFFFF6, 32'h0, 0, 1});
        tbl.push_back('{0, A_CTRL, 4'h0, 32'h0, 32'h6, 0, 1});
        tbl.push_back('{0, A_CTRL, 4'hE, 32'hFFFFFFFF, 32'h6, 0, 1});
        tbl.push_back('{0, A_CTRL, 4'h0, 32'h0, 32'h6, 0, 1});
        tbl.push_back('{0, A_CTRL, 4'h1, 32'h0, 32'h6, 0, 1});
        tbl.push_back('{0, A_CTRL, 4'h0, 32'h0, 32'h0, 0, 1});
        tbl.push_back('{0, 32'h0000_0004, 4'h0, 32'h0, 32'h0, 0, 1});
        tbl.push_back('{0, A_PRE,  4'h1, 32'h000000FF, 32'h1122AA44, 0, 1});
        tbl.push_back('{0, A_PRE,  4'h0, 32'h0, 32'h1122AAFF, 0, 1});
        tbl.push_back('{0, BASE + 32'h14, 4'hF, 32'h0, 32'h0, 0, 1});
        tbl.push_back('{0, A_PRE,  4'h0, 32'h0, 32'h1122AAFF, 0, 1});

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].a, tbl[i].be, tbl[i].wd);
            if (tbl[i].chk) begin
                check($sformatf("vec%0d_rdata", i), rdata, tbl[i].exp_rd);
                check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, tbl[i].exp_irq});
            end
            tick();
        end

        // One-shot, PRESET=5: COUNT 5..0 from E2, irq at E0+7, then held
        do_reset();
        wr(A_PRE, 32'd5);
        wr(A_CTRL, 32'h9);
        rd(A_CNT);
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("oneshot_count_e%0d", k), rdata, (k < 2) ? 32'd0 : 32'(7 - k));
            check($sformatf("oneshot_irq_e%0d", k), {31'd0, irq}, (k == 7) ? 32'd1 : 32'd0);
        end
        rd(A_CTRL);
        for (int k = 8; k <= 10; k++) begin
            tick();
            check($sformatf("oneshot_ctrl_e%0d", k), rdata, 32'h8);
            check($sformatf("oneshot_hold_e%0d", k), {31'd0, irq}, 32'd1);
        end
        wr(A_CTRL, 32'h8);
        check("oneshot_clear_irq", {31'd0, irq}, 32'd0);
        check("oneshot_clear_ctrl", rdata, 32'h8);

        // PRESET 0 and 1 both expire at E0+3
        for (int n = 0; n <= 1; n++) begin
            do_reset();
            wr(A_PRE, 32'(n));
            wr(A_CTRL, 32'h9);
            rd(A_CNT);
            for (int k = 1; k <= 4; k++) begin
                tick();
                check($sformatf("small%0d_irq_e%0d", n, k), {31'd0, irq}, (k >= 3) ? 32'd1 : 32'd0);
            end
            check($sformatf("small%0d_count", n), rdata, 32'd0);
        end

        // Auto-reload, PRESET=3: one-cycle pulse every 5 cycles, EN stays set
        do_reset();
        wr(A_PRE, 32'd3);
        wr(A_CTRL, 32'hB);
        rd(A_CTRL);
        for (int k = 1; k <= 25; k++) begin
            tick();
            check($sformatf("reload_irq_e%0d", k), {31'd0, irq},
                  (k >= 5 && (k % 5) == 0) ? 32'd1 : 32'd0);
            check($sformatf("reload_en_e%0d", k), {31'd0, rdata[0]}, 32'd1);
        end
        wr(A_CTRL, 32'h0);
        tick(); tick(); tick();
        check("reload_off_irq", {31'd0, irq}, 32'd0);

        // Masked one-shot: expires silently and clears EN
        do_reset();
        wr(A_PRE, 32'd2);
        wr(A_CTRL, 32'h1);
        rd(A_CNT);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("mask_irq_e%0d", k), {31'd0, irq}, 32'd0);
        end
        check("mask_count", rdata, 32'd0);
        rd(A_CTRL);
        check("mask_ctrl", rdata, 32'd0);

        // CTRL write on the INT edge keeps EN and clears the flag
        do_reset();
        wr(A_PRE, 32'd2);
        wr(A_CTRL, 32'h9);
        rd(A_CTRL);
        for (int k = 1; k <= 4; k++) tick();
        check("ovr_irq_int", {31'd0, irq}, 32'd1);
        wr(A_CTRL, 32'h9);
        check("ovr_ctrl", rdata, 32'h9);
        check("ovr_irq_cleared", {31'd0, irq}, 32'd0);
        rd(A_CTRL);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("ovr_rerun_irq_%0d", k), {31'd0, irq}, (k == 4) ? 32'd1 : 32'd0);
        end

        // Disable mid-count freezes COUNT; re-enable reloads; reset clears all
        do_reset();
        wr(A_PRE, 32'd10);
        wr(A_CTRL, 32'h9);
        rd(A_CNT);
        for (int k = 1; k <= 4; k++) tick();
        check("dis_count_e4", rdata, 32'd8);
        wr(A_CTRL, 32'h8);
        rd(A_CNT);
        check("dis_count_e5", rdata, 32'd7);
        for (int k = 6; k <= 10; k++) begin
            tick();
            check($sformatf("dis_frozen_e%0d", k), rdata, 32'd7);
            check($sformatf("dis_irq_e%0d", k), {31'd0, irq}, 32'd0);
        end
        wr(A_CTRL, 32'h9);
        rd(A_CNT);
        tick();
        check("reen_count_f1", rdata, 32'd7);
        tick();
        check("reen_count_f2", rdata, 32'd10);
        tick();
        check("reen_count_f3", rdata, 32'd9);
        drive(1, A_CNT, 4'h0, 32'd0);
        tick();
        drive(0, A_CTRL, 4'h0, 32'd0);
        check("midrst_ctrl", rdata, 32'd0);
        rd(A_PRE);
        check("midrst_preset", rdata, 32'd0);
        rd(A_CNT);
        check("midrst_count", rdata, 32'd0);
        rd(A_RSV);
        check("midrst_rsv", rdata, 32'd0);
        check("midrst_irq", {31'd0, irq}, 32'd0);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            int unsigned r;
            logic [31:0] a, wd;
            logic [3:0]  be;
            bit          rs;
            r  = $urandom_range(0, 99);
            rs = 0; be = 4'h0; wd = 32'd0;
            a  = BASE + 32'(4 * $urandom_range(0, 3));
            if (r < 2) begin
                rs = 1;
            end else if (r < 68) begin
                be = 4'h0;
            end else if (r < 80) begin
                a  = A_CTRL;
                be = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom_range(0, 15));
                wd = {$urandom} & 32'hFFFF_FFF0;
                wd[0]   = ($urandom_range(0, 3) != 0);
                wd[2:1] = 2'($urandom_range(0, 3));
                wd[3]   = 1'($urandom_range(0, 1));
            end else if (r < 90) begin
                a  = A_PRE;
                be = 4'($urandom_range(1, 15));
                wd = 32'($urandom_range(0, 6));
            end else if (r < 95) begin
                a  = ($urandom_range(0, 1) != 0) ? A_CNT : A_RSV;
                be = 4'($urandom_range(1, 15));
                wd = $urandom;
            end else begin
                a  = $urandom;
                if (a[31:4] == BASE[31:4]) a[20] = ~a[20];
                be = 4'($urandom_range(0, 15));
                wd = $urandom;
            end
            drive(rs, a, be, wd);
            check("rand_rdata", rdata, mread(a));
            check("rand_irq", {31'd0, irq}, {31'd0, m_flag & m_im});
            @(posedge clk);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
